// File: rtl/led_breathe_pwm.sv
// LED breathing stage: PWM output whose duty ramps 0..max, holds, ramps down, holds, repeats.
// Duty is applied only at frame boundaries so the LED waveform never glitches.
module led_breathe_pwm #(
  parameter int PWM_BITS   = 8,
  parameter int STEP_CLKS  = 98_039,
  parameter int HOLD_STEPS = 32
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  output logic                o_LED_1,
  output logic [PWM_BITS-1:0] o_Duty,
  output logic [2:0]          o_State
);

  localparam int STEP_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ZERO = {PWM_BITS{1'b0}};
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CLKS - 1);
  localparam logic [STEP_W-1:0]   STEP_ZERO = {STEP_W{1'b0}};
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [HOLD_W-1:0]   HOLD_ZERO = {HOLD_W{1'b0}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_UP      = 3'd1;
  localparam logic [2:0] S_HOLD_HI = 3'd2;
  localparam logic [2:0] S_DOWN    = 3'd3;
  localparam logic [2:0] S_HOLD_LO = 3'd4;

  logic [PWM_BITS-1:0] r_pwm_cnt, w_pwm_cnt;
  logic [STEP_W-1:0]   r_step_cnt, w_step_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt;
  logic [PWM_BITS-1:0] r_Target, w_Target;
  logic [PWM_BITS-1:0] r_Duty, w_Duty;
  logic [2:0]          r_State, w_State;
  logic                r_LED, w_LED;
  logic                w_tick;

  // Next-state logic: disable has priority over everything, including the step tick.
  always_comb begin
    w_pwm_cnt  = r_pwm_cnt;
    w_step_cnt = r_step_cnt;
    w_hold_cnt = r_hold_cnt;
    w_Target   = r_Target;
    w_Duty     = r_Duty;
    w_State    = r_State;
    w_LED      = 1'b0;
    w_tick     = (r_step_cnt == STEP_LAST);

    if (!i_Enable) begin
      w_pwm_cnt  = DUTY_ZERO;
      w_step_cnt = STEP_ZERO;
      w_hold_cnt = HOLD_ZERO;
      w_Target   = DUTY_ZERO;
      w_Duty     = DUTY_ZERO;
      w_State    = S_IDLE;
      w_LED      = 1'b0;
    end else if (r_State == S_IDLE) begin
      w_pwm_cnt  = DUTY_ZERO;
      w_step_cnt = STEP_ZERO;
      w_hold_cnt = HOLD_ZERO;
      w_Target   = DUTY_ZERO;
      w_Duty     = DUTY_ZERO;
      w_State    = S_UP;
      w_LED      = 1'b0;
    end else begin
      w_pwm_cnt  = r_pwm_cnt + 1'b1;
      w_step_cnt = w_tick ? STEP_ZERO : (r_step_cnt + 1'b1);
      w_LED      = (r_pwm_cnt < r_Duty);
      w_Duty     = (r_pwm_cnt == DUTY_MAX) ? r_Target : r_Duty;

      if (w_tick) begin
        case (r_State)
          S_UP: begin
            if (r_Target == DUTY_MAX) begin
              w_State    = S_HOLD_HI;
              w_hold_cnt = HOLD_ZERO;
            end else begin
              w_Target = r_Target + 1'b1;
            end
          end
          S_HOLD_HI: begin
            if (r_hold_cnt == HOLD_LAST) begin
              w_State = S_DOWN;
            end else begin
              w_hold_cnt = r_hold_cnt + 1'b1;
            end
          end
          S_DOWN: begin
            if (r_Target == DUTY_ZERO) begin
              w_State    = S_HOLD_LO;
              w_hold_cnt = HOLD_ZERO;
            end else begin
              w_Target = r_Target - 1'b1;
            end
          end
          S_HOLD_LO: begin
            if (r_hold_cnt == HOLD_LAST) begin
              w_State = S_UP;
            end else begin
              w_hold_cnt = r_hold_cnt + 1'b1;
            end
          end
          default: begin
            w_State = S_IDLE;
          end
        endcase
      end else begin
        w_State = r_State;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_pwm_cnt  <= DUTY_ZERO;
      r_step_cnt <= STEP_ZERO;
      r_hold_cnt <= HOLD_ZERO;
      r_Target   <= DUTY_ZERO;
      r_Duty     <= DUTY_ZERO;
      r_State    <= S_IDLE;
      r_LED      <= 1'b0;
    end else begin
      r_pwm_cnt  <= w_pwm_cnt;
      r_step_cnt <= w_step_cnt;
      r_hold_cnt <= w_hold_cnt;
      r_Target   <= w_Target;
      r_Duty     <= w_Duty;
      r_State    <= w_State;
      r_LED      <= w_LED;
    end
  end

  assign o_LED_1 = r_LED;
  assign o_Duty  = r_Duty;
  assign o_State = r_State;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Scoreboard bench for led_breathe_pwm with PWM_BITS=3, STEP_CLKS=4, HOLD_STEPS=2.
// Expected outputs come from a closed-form timeline of the breathing cycle.
module tb_led_breathe_pwm;
  localparam int PB = 3;
  localparam int SC = 4;
  localparam int HS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       led;
  logic [2:0] duty;
  logic [2:0] state;

  always #5 clk = ~clk;

  led_breathe_pwm #(.PWM_BITS(PB), .STEP_CLKS(SC), .HOLD_STEPS(HS)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .i_Enable(en),
    .o_LED_1 (led),
    .o_Duty  (duty),
    .o_State (state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] dt;
    logic       ld;
  } exp_t;

  localparam exp_t ZERO = '{st: 3'd0, dt: 3'd0, ld: 1'b0};

  exp_t  q[$];
  string tq[$];
  int    total = 0;
  int    bad = 0;
  exp_t  mon_e;
  string mon_t;

  // One breathing period is 20 ticks: 8 UP, 2 HOLD_HI, 8 DOWN, 2 HOLD_LO.
  function automatic int tgt(int j);
    int m;
    m = j % 20;
    if (m <= 7) return m;
    else if (m <= 9) return 7;
    else if (m <= 17) return 17 - m;
    else return 0;
  endfunction

  function automatic int stv(int j);
    int m;
    m = j % 20;
    if (m <= 7) return 1;
    else if (m <= 9) return 2;
    else if (m <= 17) return 3;
    else return 4;
  endfunction

  // Duty after edge n (edge 1 = leaving IDLE); loads at edges 9, 17, ... with the
  // target reached after edge 8f.
  function automatic int m_duty(int n);
    int f;
    f = (n - 1) / 8;
    if (f == 0) return 0;
    else return tgt(2 * f - 1);
  endfunction

  function automatic exp_t model(int n);
    exp_t e;
    e.st = 3'(stv((n - 1) / 4));
    e.dt = 3'(m_duty(n));
    if (n == 1) e.ld = 1'b0;
    else e.ld = (((n - 2) % 8) < m_duty(n - 1));
    return e;
  endfunction

  task automatic check(string tag, exp_t e);
    total++;
    if ({state, duty, led} !== e) begin
      bad++;
      $display("FAIL %s t=%0t: got st=%0d duty=%0d led=%0b want st=%0d duty=%0d led=%0b",
               tag, $time, state, duty, led, e.st, e.dt, e.ld);
    end
  endtask

  // Monitor: compare the oldest pending expectation away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_t = tq.pop_front();
      check(mon_t, mon_e);
    end
  end

  task automatic expect_cycle(string tag, exp_t e);
    @(posedge clk);
    q.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic run_model(string tag, int n_cycles);
    for (int n = 1; n <= n_cycles; n++) begin
      expect_cycle($sformatf("%s_n%0d", tag, n), model(n));
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) expect_cycle("reset", ZERO);
    @(negedge clk);
    rst_n = 1'b1;

    // Full up/hold/down/hold period plus a second descent to target 5.
    run_model("ramp", 130);
    @(negedge clk);
    en = 1'b0;
    repeat (4) expect_cycle("disable", ZERO);
    @(negedge clk);
    en = 1'b1;

    // Restart from duty 0; run into HOLD_HI.
    run_model("restart", 34);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.push_back(ZERO);
    tq.push_back("async_rst");
    #5 rst_n = 1'b1;
    #1 check("idle_after_rst", ZERO);
    run_model("resume", 12);

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
